// File: rtl/stream_upsizer.sv
// Stream width upsizer: packs RATIO consecutive WIDTH-bit beats into one wide beat.
// An input last marker closes a group early; out_keep marks the filled lanes.
module stream_upsizer #(
    parameter int WIDTH = 32,
    parameter int RATIO = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*RATIO-1:0] out_data,
    output logic [RATIO-1:0]       out_keep,
    output logic                   out_last
);

    localparam int CW = $clog2(RATIO);
    localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

    // Contiguous keep mask covering lanes 0..cnt.
    function automatic logic [RATIO-1:0] keep_mask(input logic [CW-1:0] cnt);
        logic [RATIO-1:0] m;
        m = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (CW'(i) <= cnt) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    logic [WIDTH*RATIO-1:0] buf_r;
    logic [CW-1:0]          count_r;
    logic                   out_valid_r;
    logic [WIDTH*RATIO-1:0] out_data_r;
    logic [RATIO-1:0]       out_keep_r;
    logic                   out_last_r;

    logic                   in_ready_s;
    logic                   accept_s;
    logic                   complete_s;
    logic [WIDTH*RATIO-1:0] merged_s;

    // Handshake decode and the assembly buffer with the incoming beat merged in.
    always_comb begin
        in_ready_s = 1'b0;
        complete_s = 1'b0;
        merged_s   = buf_r;
        if (rst) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = !out_valid_r || out_ready;
        end
        accept_s = in_valid && in_ready_s;
        if (accept_s && ((count_r == LAST_LANE) || in_last)) begin
            complete_s = 1'b1;
        end else begin
            complete_s = 1'b0;
        end
        // Lanes above count are already zero because the buffer clears per group.
        for (int i = 0; i < RATIO; i++) begin
            if (CW'(i) == count_r) begin
                merged_s[i*WIDTH +: WIDTH] = in_data;
            end else begin
                merged_s[i*WIDTH +: WIDTH] = buf_r[i*WIDTH +: WIDTH];
            end
        end
    end

    // Assembly buffer and lane counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_r   <= '0;
            count_r <= '0;
        end else if (complete_s) begin
            buf_r   <= '0;
            count_r <= '0;
        end else if (accept_s) begin
            buf_r   <= merged_s;
            count_r <= count_r + CW'(1);
        end else begin
            buf_r   <= buf_r;
            count_r <= count_r;
        end
    end

    // Output register: reloads on group completion, drops valid on a plain drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_keep_r  <= '0;
            out_last_r  <= 1'b0;
        end else if (complete_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= merged_s;
            out_keep_r  <= keep_mask(count_r);
            out_last_r  <= in_last;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
            out_keep_r  <= out_keep_r;
            out_last_r  <= out_last_r;
        end else begin
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
            out_keep_r  <= out_keep_r;
            out_last_r  <= out_last_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_keep  = out_keep_r;
    assign out_last  = out_last_r;

endmodule

// File: doc/stream_upsizer.md
Name: stream_upsizer

Overview:
- Stream width upsizer that sits directly downstream of pipeline_reg and consumes its WIDTH-bit valid/ready output stream.
- Packs RATIO consecutive input beats into one WIDTH*RATIO-bit output beat for the wider datapath stage that follows.
- An input last marker closes a group early; a lane-keep mask marks which lanes are filled.
- Valid/ready handshake on both sides. The output is registered.

Parameters:
- WIDTH, 32: width of one input beat in bits.
- RATIO, 2: input beats per output beat. Legal range is 2..8.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  WIDTH  upstream beat payload.
- in_last  input  1  beat closes the current group, even if the group is partial.
- out_valid  output  1  packed beat valid.
- out_ready  input  1  downstream accepts the packed beat.
- out_data  output  WIDTH*RATIO  packed payload. Lane i is out_data[i*WIDTH +: WIDTH]; lane 0 holds the first beat of the group.
- out_keep  output  RATIO  bit i set means lane i holds a real beat.
- out_last  output  1  the group was closed by in_last.

Behaviour:
- Reset: when rst is sampled high, all of the following clear on that edge and any partial group is discarded, including a reset asserted mid-group:
  - out_valid = 0, out_data = 0, out_keep = 0, out_last = 0
  - lane count = 0, assembly buffer = 0
- Reset has priority over every other event in the same cycle.
- Internal state:
  - Assembly buffer (RATIO lanes).
  - Lane count, 0..RATIO-1, width $clog2(RATIO).
  - Output register holding out_data, out_keep and out_last.
- Ready:
  - in_ready = !out_valid || out_ready, combinational. It does not depend on in_valid or in_last.
  - in_ready is 0 while rst is high.
- Accept: a beat transfers when in_valid && in_ready. in_data is written into lane[count].
- A group completes when a beat is accepted with count == RATIO-1 or in_last == 1. On that same edge:
  - The output register loads the assembly buffer plus the incoming lane.
  - out_keep = (1 << (count+1)) - 1.
  - out_last = in_last.
  - Unfilled lanes in out_data are driven 0.
  - out_valid becomes 1.
  - count returns to 0 and the assembly buffer clears.
- Non-completing accepted beat: count increments by 1. The output register is unchanged.
- Latency: out_valid rises the cycle after the completing beat is accepted.
- Throughput: with out_ready held at 1, the block accepts one beat per cycle and emits one packed beat per RATIO input beats, with no bubbles.
- Output handshake:
  - The beat transfers when out_valid && out_ready.
  - If no new group completes on that edge, out_valid drops to 0.
  - If a group completes on the same edge as a drain, the register reloads and out_valid stays 1, so back-to-back output works.
- Stall: while out_valid && !out_ready, out_data, out_keep and out_last hold stable and in_ready = 0. The partial group is frozen.
- in_last on lane RATIO-1: the result is a full group with out_last = 1 and all keep bits set.
- in_last on the first beat of a group: out_keep = 1 and only lane 0 is valid.
- When in_valid && !in_ready, in_data and in_last are ignored and no state changes.
- Values on in_data, in_last and out_ready are don't-care while the corresponding valid/ready is low.

Test Plan:
1. Reset: hold rst=1 for 5 cycles with in_valid=1. Required: in_ready=0, out_valid=0, out_data=0, out_keep=0, out_last=0. After release, the first accepted beat lands in lane 0.
2. Back-to-back: send 10, 11, 12, 13 with out_ready=1 and in_last=0 (RATIO=2).
   - Required outputs, each 1 cycle after its pair completes, with no bubbles: out_data=0x0000000B_0000000A with keep=2'b11, last=0; then 0x0000000D_0000000C with keep=2'b11, last=0.
3. Early last: send 0xDEADBEEF with in_last=1 as the first beat of a group. Required: out_data=0x00000000_DEADBEEF, out_keep=2'b01, out_last=1. The next beat lands in lane 0.
4. Backpressure:
   - Setup: out_ready=0; complete group 0x1/0x2; then send 0x3.
   - While stalled: out_data stays 0x00000002_00000001, in_ready=0, 0x3 is not accepted.
   - After raising out_ready: the first packet drains, then 0x3 and a following 0x4 produce 0x00000004_00000003.
5. Reset mid-group: accept 0x55 (count=1), then pulse rst for 1 cycle, then send 0xA0, 0xA1. Required: out_data=0x000000A1_000000A0; 0x55 never appears.
6. Random handshake: run 500 cycles with random in_valid, out_ready and in_last (10%), and compare against a scoreboard model. Required:
   - No lost or duplicated beats.
   - Lane order is preserved.
   - out_keep is contiguous from lane 0.
   - Output is stable under stall.
   - Run with both RATIO=2 and RATIO=4.
